oam_dma_arbiter: RTL and testbench

OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

---
 rtl/oam_dma_arbiter.sv | 136 +++++++++++++
 tb/tb_oam_dma_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : oam_dma_arbiter
//  Description : Sprite DMA engine. It stalls the CPU, copies one 256-byte
//                page to the PPU OAM data port and decodes device selects.
//  Revision    : 1.0 - initial release
// ============================================================================
module oam_dma_arbiter #(
    parameter logic [15:0] DMA_TRIGGER_ADDR = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR    = 16'h2004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpuAddr,
    input  logic        cpuRW,
    input  logic [7:0]  cpuDataOut,
    input  logic [7:0]  busData,
    output logic        cpuRdy,
    output logic [15:0] busAddr,
    output logic        busRW,
    output logic [7:0]  busDataOut,
    output logic        ppuEnable,
    output logic        controller1Enable,
    output logic        controller2Enable,
    output logic        sramEnable,
    output logic        cartridgeEnable,
    output logic        dmaActive
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } stateType;

    stateType   r_state;
    logic       r_parity;
    logic [7:0] r_page;
    logic [7:0] r_counter;
    logic [7:0] r_byte;

    logic       w_trigger;
    logic       w_busIdle;

    assign w_trigger = (cpuRW == 1'b0) && (cpuAddr == DMA_TRIGGER_ADDR);

    // The trigger is only looked at in IDLE, so a write during a DMA is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_parity  <= 1'b0;
            r_page    <= 8'h00;
            r_counter <= 8'h00;
            r_byte    <= 8'h00;
        end else begin
            r_parity <= ~r_parity;
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_state   <= ST_HALT;
                        r_page    <= cpuDataOut;
                        r_counter <= 8'h00;
                    end
                end
                // Parity 1 here means the next cycle is parity 0, a legal read slot.
                ST_HALT:  r_state <= r_parity ? ST_READ : ST_ALIGN;
                ST_ALIGN: r_state <= ST_READ;
                ST_READ: begin
                    r_byte  <= busData;
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (r_counter == 8'hFF) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_counter <= r_counter + 8'd1;
                        r_state   <= ST_READ;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cpuRdy    = (r_state == ST_IDLE);
    assign dmaActive = (r_state != ST_IDLE);

    always_comb begin
        busAddr    = cpuAddr;
        busRW      = cpuRW;
        busDataOut = cpuDataOut;
        w_busIdle  = 1'b0;
        case (r_state)
            ST_HALT, ST_ALIGN: begin
                busRW     = 1'b1;
                w_busIdle = 1'b1;
            end
            ST_READ: begin
                busAddr = {r_page, r_counter};
                busRW   = 1'b1;
            end
            ST_WRITE: begin
                busAddr    = OAM_DATA_ADDR;
                busRW      = 1'b0;
                busDataOut = r_byte;
            end
            default: ;
        endcase
    end

    // Priority chain keeps the selects mutually exclusive.
    always_comb begin
        ppuEnable         = 1'b1;
        controller1Enable = 1'b1;
        controller2Enable = 1'b1;
        sramEnable        = 1'b1;
        cartridgeEnable   = 1'b1;
        if (!w_busIdle) begin
            if (busAddr <= 16'h1FFF) begin
                sramEnable = 1'b0;
            end else if (busAddr <= 16'h3FFF) begin
                ppuEnable = 1'b0;
            end else if ((busAddr == 16'h4016) && busRW) begin
                controller1Enable = 1'b0;
            end else if ((busAddr == 16'h4017) && busRW) begin
                controller2Enable = 1'b0;
            end else if (busAddr >= 16'h4020) begin
                cartridgeEnable = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oam_dma_arbiter
//  Description : Directed self-checking bench for oam_dma_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oam_dma_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpuAddr;
    logic        cpuRW;
    logic [7:0]  cpuDataOut;
    logic [7:0]  busData;
    logic        cpuRdy;
    logic [15:0] busAddr;
    logic        busRW;
    logic [7:0]  busDataOut;
    logic        ppuEnable;
    logic        controller1Enable;
    logic        controller2Enable;
    logic        sramEnable;
    logic        cartridgeEnable;
    logic        dmaActive;
    logic [4:0]  en;

    int nVec = 0;
    int nErr = 0;
    int cyc  = 0;

    always #5 clk = ~clk;

    oam_dma_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .cpuAddr           (cpuAddr),
        .cpuRW             (cpuRW),
        .cpuDataOut        (cpuDataOut),
        .busData           (busData),
        .cpuRdy            (cpuRdy),
        .busAddr           (busAddr),
        .busRW             (busRW),
        .busDataOut        (busDataOut),
        .ppuEnable         (ppuEnable),
        .controller1Enable (controller1Enable),
        .controller2Enable (controller2Enable),
        .sramEnable        (sramEnable),
        .cartridgeEnable   (cartridgeEnable),
        .dmaActive         (dmaActive)
    );

    // Order: ppu, ctrl1, ctrl2, sram, cart
    assign en = {ppuEnable, controller1Enable, controller2Enable, sramEnable, cartridgeEnable};

    // Memory image seen on the read-data bus
    function automatic logic [7:0] memByte(input logic [15:0] a);
        return (a[7:0] ^ 8'hA5) + a[15:8];
    endfunction

    assign busData = memByte(busAddr);

    task automatic step();
        @(negedge clk);
        cyc = cyc + 1;
    endtask

    task automatic cpuIdle();
        cpuAddr    = 16'h8000;
        cpuRW      = 1'b1;
        cpuDataOut = 8'h77;
    endtask

    // After this, the current cycle is cycle 0 (reset released, parity 0)
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        cpuIdle();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset      = 1'b1;
        cpuAddr    = 16'h0123;
        cpuRW      = 1'b1;
        cpuDataOut = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        nVec++; if (cpuRdy !== 1'b1) begin nErr++; $display("FAIL reset_cpuRdy got %b want 1", cpuRdy); end
        nVec++; if (dmaActive !== 1'b0) begin nErr++; $display("FAIL reset_dmaActive got %b want 0", dmaActive); end
        nVec++; if (en !== 5'b11101) begin nErr++; $display("FAIL reset_enables got %b want 11101", en); end
        nVec++; if (busAddr !== 16'h0123) begin nErr++; $display("FAIL reset_busAddr got %h want 0123", busAddr); end
    endtask

    task automatic test_decode();
        logic [15:0] addrs [9] = '{16'h2002, 16'h4016, 16'h4017, 16'h8000, 16'h4018,
                                   16'h4016, 16'h1FFF, 16'h401F, 16'h4020};
        logic        rws   [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [4:0]  exps  [9] = '{5'b01111, 5'b10111, 5'b11011, 5'b11110, 5'b11111,
                                   5'b11111, 5'b11101, 5'b11111, 5'b11110};
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            step();
            cpuAddr    = addrs[i];
            cpuRW      = rws[i];
            cpuDataOut = 8'h3C;
            #1;
            nVec++; if (en !== exps[i]) begin nErr++; $display("FAIL decode_%0d enables got %b want %b", i, en, exps[i]); end
            nVec++; if (busAddr !== addrs[i] || busRW !== rws[i] || busDataOut !== 8'h3C) begin
                nErr++; $display("FAIL decode_%0d passthrough got %h/%b/%h want %h/%b/3c", i, busAddr, busRW, busDataOut, addrs[i], rws[i]);
            end
            nVec++; if (cpuRdy !== 1'b1 || dmaActive !== 1'b0) begin
                nErr++; $display("FAIL decode_%0d idle got rdy=%b act=%b want 1/0", i, cpuRdy, dmaActive);
            end
        end
        step();
        cpuIdle();
        #1;
        nVec++; if (dmaActive !== 1'b0) begin nErr++; $display("FAIL decode_nodma got %b want 0", dmaActive); end
    endtask

    // Trigger write in cycle trig; optional ignored re-trigger mid-transfer
    task automatic test_dma(input int trig, input logic [7:0] page, input bit inject, input int expStall);
        int h, fR, lastW, k, stall;
        logic [15:0] ea;
        apply_reset();
        while (cyc < trig) step();
        cpuAddr    = 16'h4014;
        cpuRW      = 1'b0;
        cpuDataOut = page;
        #1;
        nVec++; if (cpuRdy !== 1'b1) begin nErr++; $display("FAIL dma_trigcycle cpuRdy got %b want 1", cpuRdy); end
        h     = trig + 1;
        fR    = (h % 2 == 1) ? h + 1 : h + 2;
        lastW = fR + 511;
        stall = 0;
        for (int c = h; c <= lastW + 1; c++) begin
            step();
            cpuIdle();
            if (inject && c == fR + 51) begin
                cpuAddr    = 16'h4014;
                cpuRW      = 1'b0;
                cpuDataOut = 8'h05;
            end
            #1;
            if (cpuRdy === 1'b0) stall++;
            if (c < fR) begin
                nVec++; if (cpuRdy !== 1'b0 || dmaActive !== 1'b1 || busRW !== 1'b1 || en !== 5'b11111 || busAddr !== cpuAddr) begin
                    nErr++; $display("FAIL dma_halt cyc %0d got rdy=%b act=%b rw=%b en=%b addr=%h want 0/1/1/11111/%h",
                                     c, cpuRdy, dmaActive, busRW, en, busAddr, cpuAddr);
                end
            end else if (c <= lastW) begin
                k = (c - fR) / 2;
                if ((c - fR) % 2 == 0) begin
                    ea = {page, k[7:0]};
                    nVec++; if (cpuRdy !== 1'b0 || busRW !== 1'b1 || busAddr !== ea) begin
                        nErr++; $display("FAIL dma_read cyc %0d got rdy=%b rw=%b addr=%h want 0/1/%h", c, cpuRdy, busRW, busAddr, ea);
                    end
                end else begin
                    ea = {page, k[7:0]};
                    nVec++; if (cpuRdy !== 1'b0 || busRW !== 1'b0 || busAddr !== 16'h2004 || busDataOut !== memByte(ea) || en !== 5'b01111) begin
                        nErr++; $display("FAIL dma_write cyc %0d got rdy=%b rw=%b addr=%h data=%h en=%b want 0/0/2004/%h/01111",
                                         c, cpuRdy, busRW, busAddr, busDataOut, en, memByte(ea));
                    end
                end
            end else begin
                nVec++; if (cpuRdy !== 1'b1 || dmaActive !== 1'b0 || busAddr !== 16'h8000 || en !== 5'b11110) begin
                    nErr++; $display("FAIL dma_done cyc %0d got rdy=%b act=%b addr=%h en=%b want 1/0/8000/11110",
                                     c, cpuRdy, dmaActive, busAddr, en);
                end
            end
        end
        nVec++; if (stall !== expStall) begin nErr++; $display("FAIL dma_stall_len got %0d want %0d", stall, expStall); end
        for (int i = 0; i < 4; i++) begin
            step();
            cpuIdle();
            #1;
            nVec++; if (dmaActive !== 1'b0 || cpuRdy !== 1'b1) begin
                nErr++; $display("FAIL dma_after cyc %0d got act=%b rdy=%b want 0/1", cyc, dmaActive, cpuRdy);
            end
        end
    endtask

    task automatic test_no_trigger();
        apply_reset();
        step(); step();
        cpuAddr = 16'h4014; cpuRW = 1'b1; cpuDataOut = 8'h09;
        step();
        cpuIdle();
        #1;
        nVec++; if (dmaActive !== 1'b0 || cpuRdy !== 1'b1) begin
            nErr++; $display("FAIL notrig_read got act=%b rdy=%b want 0/1", dmaActive, cpuRdy);
        end
        cpuAddr = 16'h4000; cpuRW = 1'b0; cpuDataOut = 8'h09;
        step();
        cpuIdle();
        #1;
        nVec++; if (dmaActive !== 1'b0 || cpuRdy !== 1'b1) begin
            nErr++; $display("FAIL notrig_otherwrite got act=%b rdy=%b want 0/1", dmaActive, cpuRdy);
        end
    endtask

    task automatic test_mid_reset();
        int wr, act;
        apply_reset();
        while (cyc < 4) step();
        cpuAddr = 16'h4014; cpuRW = 1'b0; cpuDataOut = 8'h02;
        while (cyc < 206) begin step(); cpuIdle(); end
        #1;
        nVec++; if (busAddr !== 16'h0264 || busRW !== 1'b1) begin
            nErr++; $display("FAIL midrst_read100 got addr=%h rw=%b want 0264/1", busAddr, busRW);
        end
        reset = 1'b1;
        step();
        #1;
        nVec++; if (cpuRdy !== 1'b1 || dmaActive !== 1'b0 || busAddr !== 16'h8000) begin
            nErr++; $display("FAIL midrst_idle got rdy=%b act=%b addr=%h want 1/0/8000", cpuRdy, dmaActive, busAddr);
        end
        reset = 1'b0;
        wr  = 0;
        act = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            #1;
            if (busRW === 1'b0 && busAddr === 16'h2004) wr++;
            if (dmaActive !== 1'b0) act++;
        end
        nVec++; if (wr !== 0) begin nErr++; $display("FAIL midrst_oamwrites got %0d want 0", wr); end
        nVec++; if (act !== 0) begin nErr++; $display("FAIL midrst_active got %0d want 0", act); end
    endtask

    initial begin
        reset = 1'b1;
        cpuIdle();
        test_reset();
        test_decode();
        test_dma(4, 8'h02, 1'b0, 513);
        test_dma(5, 8'h02, 1'b0, 514);
        test_dma(4, 8'h02, 1'b1, 513);
        test_dma(7, 8'hC3, 1'b0, 514);
        test_no_trigger();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire
